// File: rtl/slow_access_ctl_pkg.sv
// Shared definitions for the slow-access controller.
//   state_e : FSM state encoding (IDLE / ACCESS / HOLD)
//   CNT_W   : width of the post-access hold counter, in ticks
package slow_access_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/slow_access_ctl_tick_gen.sv
// Timeout tick prescaler for slow_access_ctl.
// Pulses tick_o for one CLK cycle every TICK_DIV cycles. clr_i restarts the
// count, so the first tick after a clear lands TICK_DIV cycles later.
// Ports:
//   CLK    in  system clock
//   nPOR   in  synchronous active-low reset
//   clr_i  in  synchronous prescaler clear
//   tick_o out one-cycle tick pulse
module slow_tick_gen #(
  parameter int unsigned TICK_DIV = 16
) (
  input  logic CLK,
  input  logic nPOR,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;

  always_comb begin
    pre_d = pre_q + PW'(1);
    if (clr_i || (pre_q == LAST)) begin
      pre_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nPOR) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign tick_o = (pre_q == LAST);

endmodule

// File: rtl/slow_access_ctl.sv
// Slow-device access controller.
// Asserts Slow for every new bus cycle that hits an enabled slow device, then
// holds it for SlowTimeout ticks after the access before releasing it.
// ClockGateEn follows Slow when clock gating was enabled at access start.
// Ports:
//   CLK, nPOR                         clock, synchronous active-low reset
//   BACT                              bus cycle active
//   IACKCS..SndCSWR                   device selects
//   SlowIACK..SlowSnd                 per-device slow enables
//   SlowClockGate                     enable clock gating while slow
//   SlowTimeout[3:0]                  post-access hold in ticks
//   Slow, ClockGateEn                 registered outputs
//
// state     | meaning
// ----------+----------------------------------------------------
// ST_IDLE   | no slow access; Slow=0
// ST_ACCESS | slow bus cycle in progress; Slow=1
// ST_HOLD   | post-access hold, Cnt counts down on ticks; Slow=1
module slow_access_ctl
  import slow_access_ctl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 16
) (
  input  logic             CLK,
  input  logic             nPOR,
  input  logic             BACT,
  input  logic             IACKCS,
  input  logic             VIACS,
  input  logic             IWMCS,
  input  logic             SCCCS,
  input  logic             SCSICS,
  input  logic             SndCSWR,
  input  logic             SlowIACK,
  input  logic             SlowVIA,
  input  logic             SlowIWM,
  input  logic             SlowSCC,
  input  logic             SlowSCSI,
  input  logic             SlowSnd,
  input  logic             SlowClockGate,
  input  logic [CNT_W-1:0] SlowTimeout,
  output logic             Slow,
  output logic             ClockGateEn
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gate_q, gate_d;
  logic             bactr_q;
  logic             slow_q, cge_q;
  logic             hit, start, tick, presc_clr;

  assign hit = (IACKCS & SlowIACK) | (VIACS & SlowVIA) | (IWMCS & SlowIWM) |
               (SCCCS & SlowSCC) | (SCSICS & SlowSCSI) | (SndCSWR & SlowSnd);

  // Only the rising edge of BACT can start an access.
  assign start = BACT & ~bactr_q & hit;

  slow_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .CLK    (CLK),
    .nPOR   (nPOR),
    .clr_i  (presc_clr),
    .tick_o (tick)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gate_d    = gate_q;
    presc_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACCESS;
          cnt_d   = SlowTimeout;
          gate_d  = SlowClockGate;
        end
      end
      ST_ACCESS: begin
        if (!BACT) begin
          if (cnt_q != '0) begin
            state_d   = ST_HOLD;
            presc_clr = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        // A retrigger wins over a tick in the same cycle.
        if (start) begin
          state_d = ST_ACCESS;
          cnt_d   = SlowTimeout;
          gate_d  = SlowClockGate;
        end else if (tick) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nPOR) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gate_q  <= 1'b0;
      bactr_q <= 1'b0;
      slow_q  <= 1'b0;
      cge_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gate_q  <= gate_d;
      bactr_q <= BACT;
      // Outputs are registered from next state so they line up with state_q.
      slow_q  <= (state_d != ST_IDLE);
      cge_q   <= (state_d != ST_IDLE) & gate_d;
    end
  end

  assign Slow        = slow_q;
  assign ClockGateEn = cge_q;

endmodule

// File: tb/tb_slow_access_ctl.sv
module tb_slow_access_ctl;
  import slow_access_ctl_pkg::*;

  localparam int unsigned TD = 16;

  logic       CLK = 1'b0;
  logic       nPOR, BACT, IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCSWR;
  logic       SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd, SlowClockGate;
  logic [3:0] SlowTimeout;
  logic       Slow, ClockGateEn;

  int checks = 0;
  int failures = 0;

  // Reference model: "in an access" flag plus remaining hold time in clocks.
  bit m_acc, m_gl, m_bactr, m_slow, m_cge;
  int m_hold;

  slow_access_ctl #(.TICK_DIV(TD)) dut (
    .CLK(CLK), .nPOR(nPOR), .BACT(BACT), .IACKCS(IACKCS), .VIACS(VIACS),
    .IWMCS(IWMCS), .SCCCS(SCCCS), .SCSICS(SCSICS), .SndCSWR(SndCSWR),
    .SlowIACK(SlowIACK), .SlowVIA(SlowVIA), .SlowIWM(SlowIWM), .SlowSCC(SlowSCC),
    .SlowSCSI(SlowSCSI), .SlowSnd(SlowSnd), .SlowClockGate(SlowClockGate),
    .SlowTimeout(SlowTimeout), .Slow(Slow), .ClockGateEn(ClockGateEn)
  );

  always #5 CLK = ~CLK;

  task automatic model_update();
    bit hit, start;
    hit = (IACKCS & SlowIACK) | (VIACS & SlowVIA) | (IWMCS & SlowIWM) |
          (SCCCS & SlowSCC) | (SCSICS & SlowSCSI) | (SndCSWR & SlowSnd);
    start = BACT && !m_bactr && hit;
    if (!nPOR) begin
      m_acc = 0; m_hold = 0; m_gl = 0; m_bactr = 0;
    end else begin
      if (start) begin
        m_acc  = 1;
        m_hold = int'(SlowTimeout) * TD;
        m_gl   = SlowClockGate;
      end else if (m_acc) begin
        if (!BACT) m_acc = 0;
      end else if (m_hold > 0) begin
        m_hold--;
      end
      m_bactr = BACT;
    end
    m_slow = m_acc || (m_hold > 0);
    m_cge  = m_slow && m_gl;
  endtask

  task automatic step();
    @(posedge CLK);
    model_update();
    #1;
    checks++;
    assert (Slow === m_slow) else begin
      failures++;
      $error("FAIL slow t=%0t got=%b exp=%b", $time, Slow, m_slow);
    end
    checks++;
    assert (ClockGateEn === m_cge) else begin
      failures++;
      $error("FAIL gate t=%0t got=%b exp=%b", $time, ClockGateEn, m_cge);
    end
  endtask

  task automatic clear_sel();
    IACKCS = 0; VIACS = 0; IWMCS = 0; SCCCS = 0; SCSICS = 0; SndCSWR = 0;
  endtask

  task automatic clear_en();
    SlowIACK = 0; SlowVIA = 0; SlowIWM = 0; SlowSCC = 0; SlowSCSI = 0; SlowSnd = 0;
    SlowClockGate = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    BACT = 0;
    clear_sel();
    while (m_slow && n < 400) begin
      step();
      n++;
    end
    checks++;
    assert (!m_slow) else begin
      failures++;
      $error("FAIL drain_timeout got=%0d exp=<400", n);
    end
    step();
  endtask

  initial begin
    int cnt;
    int n;
    m_acc = 0; m_gl = 0; m_bactr = 0; m_hold = 0; m_slow = 0; m_cge = 0;
    clear_sel(); clear_en();
    SlowTimeout = 4'd0;

    // 1: reset with a live VIA hit
    nPOR = 0; BACT = 1; VIACS = 1; SlowVIA = 1;
    step();
    step();
    checks++;
    assert (Slow === 1'b0 && ClockGateEn === 1'b0) else begin
      failures++;
      $error("FAIL reset_out got=%b%b exp=00", Slow, ClockGateEn);
    end
    BACT = 0; VIACS = 0;
    step();
    nPOR = 1;
    step(); step();

    // 2: VIA hit, timeout 3, BACT high 5 clocks
    SlowTimeout = 4'd3; VIACS = 1; BACT = 1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (Slow) cnt++;
    end
    BACT = 0; VIACS = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (Slow) cnt++;
    end
    checks++;
    assert (cnt == 5 + 3 * TD) else begin
      failures++;
      $error("FAIL via_slow_len got=%0d exp=%0d", cnt, 5 + 3 * TD);
    end
    clear_en();

    // 3: SCC without and with enable, timeout 0
    SCCCS = 1; BACT = 1;
    repeat (3) step();
    BACT = 0; SCCCS = 0;
    repeat (3) step();
    SlowSCC = 1; SlowTimeout = 4'd0; SCCCS = 1; BACT = 1;
    repeat (3) step();
    BACT = 0; SCCCS = 0;
    step();
    checks++;
    assert (Slow === 1'b0) else begin
      failures++;
      $error("FAIL scc_t0_fall got=%b exp=0", Slow);
    end
    repeat (2) step();
    clear_en();

    // 4: retrigger on the last hold cycle, coincident with a tick
    SlowIWM = 1; SlowTimeout = 4'd2; IWMCS = 1; BACT = 1;
    repeat (2) step();
    BACT = 0; IWMCS = 0;
    n = 0;
    while (m_hold != 1 && n < 200) begin
      step();
      n++;
    end
    checks++;
    assert (m_hold == 1) else begin
      failures++;
      $error("FAIL retrig_setup got=%0d exp=1", m_hold);
    end
    BACT = 1; IWMCS = 1; SlowTimeout = 4'd5;
    step();
    checks++;
    assert (dut.state_q === ST_ACCESS) else begin
      failures++;
      $error("FAIL retrig_state got=%0d exp=%0d", dut.state_q, ST_ACCESS);
    end
    checks++;
    assert (dut.cnt_q === 4'd5) else begin
      failures++;
      $error("FAIL retrig_cnt got=%0d exp=5", dut.cnt_q);
    end
    step();
    drain();
    clear_en();

    // 5: timeout changed mid-access; clock gating follows Slow
    SlowSnd = 1; SlowClockGate = 1; SlowTimeout = 4'd3; SndCSWR = 1; BACT = 1;
    step();
    SlowTimeout = 4'hF; SlowClockGate = 0;
    repeat (2) step();
    BACT = 0; SndCSWR = 0;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (Slow) cnt++;
      checks++;
      assert (ClockGateEn === Slow) else begin
        failures++;
        $error("FAIL gate_track got=%b exp=%b", ClockGateEn, Slow);
      end
    end
    checks++;
    assert (cnt == 3 * TD) else begin
      failures++;
      $error("FAIL cfg_latched_hold got=%0d exp=%0d", cnt, 3 * TD);
    end
    clear_en();

    // 6: reset asserted in HOLD with Cnt=2
    SlowSCSI = 1; SlowTimeout = 4'd3; SCSICS = 1; BACT = 1;
    repeat (2) step();
    BACT = 0; SCSICS = 0;
    n = 0;
    while (m_hold != 24 && n < 200) begin
      step();
      n++;
    end
    nPOR = 0;
    step();
    checks++;
    assert (Slow === 1'b0) else begin
      failures++;
      $error("FAIL hold_reset_slow got=%b exp=0", Slow);
    end
    checks++;
    assert (dut.cnt_q === 4'd0) else begin
      failures++;
      $error("FAIL hold_reset_cnt got=%0d exp=0", dut.cnt_q);
    end
    nPOR = 1;
    repeat (40) step();
    clear_en();

    // Random traffic against the model
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0) BACT = ~BACT;
      IACKCS  = ($urandom_range(0, 5) == 0);
      VIACS   = ($urandom_range(0, 5) == 0);
      IWMCS   = ($urandom_range(0, 5) == 0);
      SCCCS   = ($urandom_range(0, 5) == 0);
      SCSICS  = ($urandom_range(0, 5) == 0);
      SndCSWR = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 30) == 0) begin
        {SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd} = 6'($urandom);
        SlowClockGate = 1'($urandom);
      end
      if ($urandom_range(0, 10) == 0)
        SlowTimeout = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      nPOR = ($urandom_range(0, 300) != 0);
      step();
    end
    nPOR = 1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
